// File: rtl/hdmi_timing_monitor.sv
// hdmi_timing_monitor
//   Passive monitor that sits on the HDMI timing/pattern driver outputs. For
//   each frame it measures the line length, the active width, the frame height
//   and the active height. It also sums every active pixel into a 32-bit
//   checksum and reports lock against the expected format.
//
// Ports
//   clk, rst        pixel clock, synchronous active-high reset
//   hs, vs, de      horizontal sync, vertical sync, data enable (active high)
//   rgb_r/g/b       8-bit colour components of the current pixel
//   meas_h_total    clocks between the last two hs rising edges of the frame
//   meas_h_active   de-high run length of the last active line
//   meas_v_total    hs rising edges in the frame
//   meas_v_active   de runs completed in the frame
//   frame_checksum  modulo-2^32 sum of {8'h0, r, g, b} over the frame
//   meas_valid      one-cycle pulse when the published values update
//   h_unstable      some line of the published frame differed from its first line
//   locked          LOCK_FRAMES consecutive published frames matched EXP_*
//   no_signal       no hs rising edge for 4095 clocks
//   frame_cnt       count of published frames, wraps
module hdmi_timing_monitor #(
  parameter int unsigned EXP_H_TOTAL  = 2200,
  parameter int unsigned EXP_H_ACTIVE = 1920,
  parameter int unsigned EXP_V_TOTAL  = 1125,
  parameter int unsigned EXP_V_ACTIVE = 1080,
  parameter int unsigned LOCK_FRAMES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs,
  input  logic        vs,
  input  logic        de,
  input  logic [7:0]  rgb_r,
  input  logic [7:0]  rgb_g,
  input  logic [7:0]  rgb_b,
  output logic [11:0] meas_h_total,
  output logic [11:0] meas_h_active,
  output logic [11:0] meas_v_total,
  output logic [11:0] meas_v_active,
  output logic [31:0] frame_checksum,
  output logic        meas_valid,
  output logic        h_unstable,
  output logic        locked,
  output logic        no_signal,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  state_t      state_q;
  logic        hs_q, vs_q, de_q;
  logic [11:0] h_run_q, line_len_q, de_run_q, de_len_q;
  logic [11:0] line_cnt_q, line_act_cnt_q, first_len_q;
  logic        first_valid_q, h_unst_q;
  logic [31:0] acc_q;
  logic [3:0]  match_cnt_q, match_cnt_d;
  logic [11:0] meas_h_total_q, meas_h_active_q, meas_v_total_q, meas_v_active_q;
  logic [31:0] frame_checksum_q;
  logic [15:0] frame_cnt_q;
  logic        meas_valid_q, h_unstable_q, locked_q, no_signal_q;

  logic        hs_rise_s, vs_rise_s, de_fall_s;
  logic        h_loss_s, publish_s, h_diff_s, h_unst_pub_s, match_s;
  logic [31:0] pix_s;

  assign hs_rise_s = hs & ~hs_q;
  assign vs_rise_s = vs & ~vs_q;
  assign de_fall_s = ~de & de_q;
  assign pix_s     = de ? {8'h00, rgb_r, rgb_g, rgb_b} : 32'h0000_0000;

  // A returning hs edge wins over the saturated counter, so a vs that
  // coincides with the first hs after a loss still starts acquisition.
  assign h_loss_s  = (h_run_q == 12'hFFF) && !hs_rise_s;
  assign publish_s = vs_rise_s && (state_q != IDLE) && !h_loss_s;

  // The line ending on a coincident vs/hs edge still belongs to the old frame.
  assign h_diff_s     = hs_rise_s && first_valid_q && (h_run_q != first_len_q);
  assign h_unst_pub_s = h_unst_q | h_diff_s;

  assign match_s = (line_len_q     == 12'(EXP_H_TOTAL))  &&
                   (de_len_q       == 12'(EXP_H_ACTIVE)) &&
                   (line_cnt_q     == 12'(EXP_V_TOTAL))  &&
                   (line_act_cnt_q == 12'(EXP_V_ACTIVE)) &&
                   !h_unst_pub_s;

  // Next value of the consecutive-match counter for the frame being published.
  always_comb begin
    match_cnt_d = 4'd0;
    if (match_s) begin
      if (match_cnt_q >= LOCK_N) begin
        match_cnt_d = LOCK_N;
      end else begin
        match_cnt_d = match_cnt_q + 4'd1;
      end
    end else begin
      match_cnt_d = 4'd0;
    end
  end

  // Raster measurement counters, checksum accumulator and line-stability tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q           <= 1'b0;
      vs_q           <= 1'b0;
      de_q           <= 1'b0;
      h_run_q        <= 12'd0;
      line_len_q     <= 12'd0;
      de_run_q       <= 12'd0;
      de_len_q       <= 12'd0;
      line_cnt_q     <= 12'd0;
      line_act_cnt_q <= 12'd0;
      first_len_q    <= 12'd0;
      first_valid_q  <= 1'b0;
      h_unst_q       <= 1'b0;
      acc_q          <= 32'd0;
    end else begin
      hs_q <= hs;
      vs_q <= vs;
      de_q <= de;

      if (hs_rise_s) begin
        line_len_q <= h_run_q;
        h_run_q    <= 12'd1;
      end else if (h_run_q != 12'hFFF) begin
        h_run_q <= h_run_q + 12'd1;
      end

      if (de_fall_s) begin
        de_len_q <= de_run_q;
        de_run_q <= 12'd0;
      end else if (de) begin
        de_run_q <= de_run_q + 12'd1;
      end

      if (vs_rise_s) begin
        // Frame start: an hs on this same clock is line 1 of the new frame.
        line_cnt_q     <= hs_rise_s ? 12'd1 : 12'd0;
        line_act_cnt_q <= de_fall_s ? 12'd1 : 12'd0;
        acc_q          <= pix_s;
        first_valid_q  <= 1'b0;
        h_unst_q       <= 1'b0;
      end else begin
        if (hs_rise_s) begin
          line_cnt_q <= line_cnt_q + 12'd1;
          if (!first_valid_q) begin
            first_len_q   <= h_run_q;
            first_valid_q <= 1'b1;
          end else if (h_diff_s) begin
            h_unst_q <= 1'b1;
          end
        end
        if (de_fall_s) begin
          line_act_cnt_q <= line_act_cnt_q + 12'd1;
        end
        acc_q <= acc_q + pix_s;
      end
    end
  end

  // Acquisition state machine with registered publish, lock and loss outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      meas_h_total_q   <= 12'd0;
      meas_h_active_q  <= 12'd0;
      meas_v_total_q   <= 12'd0;
      meas_v_active_q  <= 12'd0;
      frame_checksum_q <= 32'd0;
      frame_cnt_q      <= 16'd0;
      meas_valid_q     <= 1'b0;
      h_unstable_q     <= 1'b0;
      locked_q         <= 1'b0;
      no_signal_q      <= 1'b0;
      match_cnt_q      <= 4'd0;
    end else begin
      meas_valid_q <= publish_s;

      if (hs_rise_s) begin
        no_signal_q <= 1'b0;
      end else if (h_loss_s) begin
        no_signal_q <= 1'b1;
      end

      if (publish_s) begin
        meas_h_total_q   <= line_len_q;
        meas_h_active_q  <= de_len_q;
        meas_v_total_q   <= line_cnt_q;
        meas_v_active_q  <= line_act_cnt_q;
        frame_checksum_q <= acc_q + pix_s;
        h_unstable_q     <= h_unst_pub_s;
        frame_cnt_q      <= frame_cnt_q + 16'd1;
        match_cnt_q      <= match_cnt_d;
        locked_q         <= (match_cnt_d == LOCK_N);
      end

      if (h_loss_s) begin
        state_q     <= IDLE;
        locked_q    <= 1'b0;
        match_cnt_q <= 4'd0;
      end else begin
        case (state_q)
          IDLE:    if (vs_rise_s) state_q <= ACQUIRE;
          ACQUIRE: if (vs_rise_s) state_q <= TRACK;
          TRACK:   state_q <= TRACK;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign meas_h_total   = meas_h_total_q;
  assign meas_h_active  = meas_h_active_q;
  assign meas_v_total   = meas_v_total_q;
  assign meas_v_active  = meas_v_active_q;
  assign frame_checksum = frame_checksum_q;
  assign meas_valid     = meas_valid_q;
  assign h_unstable     = h_unstable_q;
  assign locked         = locked_q;
  assign no_signal      = no_signal_q;
  assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_hdmi_timing_monitor.sv
// Scoreboard bench for hdmi_timing_monitor on a small 20x10 raster
// (12 active clocks per line, 6 active lines). Stimulus pushes the expected
// publish into a queue at every frame-starting vs edge. A separate monitor
// pops and compares whenever meas_valid is high.
module tb_hdmi_timing_monitor;

  localparam int CSUM_CONST = 4755672; // 72 * 24'h010203

  logic        clk = 1'b0;
  logic        rst, hs, vs, de;
  logic [7:0]  rgb_r, rgb_g, rgb_b;
  logic [11:0] meas_h_total, meas_h_active, meas_v_total, meas_v_active;
  logic [31:0] frame_checksum;
  logic        meas_valid, h_unstable, locked, no_signal;
  logic [15:0] frame_cnt;

  hdmi_timing_monitor #(
    .EXP_H_TOTAL(20), .EXP_H_ACTIVE(12), .EXP_V_TOTAL(10),
    .EXP_V_ACTIVE(6), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .hs(hs), .vs(vs), .de(de),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
    .meas_h_total(meas_h_total), .meas_h_active(meas_h_active),
    .meas_v_total(meas_v_total), .meas_v_active(meas_v_active),
    .frame_checksum(frame_checksum), .meas_valid(meas_valid),
    .h_unstable(h_unstable), .locked(locked), .no_signal(no_signal),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] ht, ha, vt, va;
    logic [31:0] cs;
    logic        hu, lk;
    logic [15:0] fc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // bench model of the frame being generated and of the acquisition/lock state
  int          since_sync = 0;
  int          mc = 0;
  int          fc = 0;
  int          fidx = 0;
  int          cur_mode = 0;
  bit          cur_wide = 1'b0;
  logic [31:0] cur_sum = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input logic h, input logic v, input logic d, input logic [23:0] p);
    @(negedge clk);
    hs = h; vs = v; de = d;
    {rgb_r, rgb_g, rgb_b} = d ? p : 24'h000000;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_h_total"}, 32'(meas_h_total), 32'd0);
    check({tag, "_h_active"}, 32'(meas_h_active), 32'd0);
    check({tag, "_v_total"}, 32'(meas_v_total), 32'd0);
    check({tag, "_v_active"}, 32'(meas_v_active), 32'd0);
    check({tag, "_checksum"}, frame_checksum, 32'd0);
    check({tag, "_valid"}, 32'(meas_valid), 32'd0);
    check({tag, "_h_unstable"}, 32'(h_unstable), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_no_signal"}, 32'(no_signal), 32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  // Called as a frame's vs is about to be driven: closes the previous frame.
  task automatic frame_start();
    exp_t e;
    if (since_sync >= 1) begin
      if (!cur_wide) mc = (mc >= 2) ? 2 : mc + 1;
      else           mc = 0;
      fc++;
      e.ht = 12'd20; e.ha = 12'd12; e.vt = 12'd10; e.va = 12'd6;
      e.cs = (cur_mode == 0) ? 32'(CSUM_CONST) : cur_sum;
      e.hu = cur_wide;
      e.lk = (mc == 2);
      e.fc = 16'(fc);
      q.push_back(e);
    end
    since_sync++;
    cur_sum  = 32'd0;
    cur_wide = 1'b0;
  endtask

  // mode 0: constant 24'h010203, mode 1: ramp. wide_line >= 0 stretches that line to 21 clocks.
  task automatic run_frame(input int mode, input int wide_line, input int nlines);
    logic [23:0] pix;
    logic        d;
    frame_start();
    cur_mode = mode;
    cur_wide = (wide_line >= 0);
    fidx++;
    for (int l = 0; l < nlines; l++) begin
      for (int c = 0; c < ((l == wide_line) ? 21 : 20); c++) begin
        d   = (l >= 2) && (l <= 7) && (c >= 4) && (c < 16);
        pix = (mode == 0) ? 24'h010203 : {8'(fidx), 8'(l * 7), 8'(c * 13)};
        if (d) cur_sum = cur_sum + {8'h00, pix};
        tick(c < 2, (l == 0) && (c < 3), d, pix);
      end
    end
  endtask

  task automatic model_resync(input bit clear_fc);
    since_sync = 0;
    mc = 0;
    if (clear_fc) fc = 0;
  endtask

  // Monitor: every published frame must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (meas_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_publish: got meas_valid=1 at frame_cnt %0d, expected no publish", frame_cnt);
        end else begin
          e = q.pop_front();
          check("h_total", 32'(meas_h_total), 32'(e.ht));
          check("h_active", 32'(meas_h_active), 32'(e.ha));
          check("v_total", 32'(meas_v_total), 32'(e.vt));
          check("v_active", 32'(meas_v_active), 32'(e.va));
          check("checksum", frame_checksum, e.cs);
          check("h_unstable", 32'(h_unstable), 32'(e.hu));
          check("locked", 32'(locked), 32'(e.lk));
          check("frame_cnt", 32'(frame_cnt), 32'(e.fc));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; hs = 1'b0; vs = 1'b0; de = 1'b0;
    rgb_r = 8'h00; rgb_g = 8'h00; rgb_b = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (5) tick(1'b0, 1'b0, 1'b0, 24'h000000);

    // smoke + constant checksum, lock at the second publish
    for (int i = 0; i < 5; i++) run_frame(0, -1, 10);
    // ramp pattern checksum
    for (int i = 0; i < 3; i++) run_frame(1, -1, 10);
    // one line widened to 21 clocks, then recovery of lock
    run_frame(0, 4, 10);
    for (int i = 0; i < 3; i++) run_frame(0, -1, 10);

    // loss of signal: partial frame, then hs held low
    run_frame(0, -1, 3);
    model_resync(1'b0);
    for (int i = 0; i < 5000; i++) begin
      tick(1'b0, 1'b0, 1'b0, 24'h000000);
      if (i == 3999) check("no_signal_early", 32'(no_signal), 32'd0);
      if (i == 4199) begin
        check("no_signal_set", 32'(no_signal), 32'd1);
        check("locked_on_loss", 32'(locked), 32'd0);
      end
    end
    run_frame(1, -1, 10);
    check("no_signal_cleared", 32'(no_signal), 32'd0);
    for (int i = 0; i < 2; i++) run_frame(1, -1, 10);

    // synchronous reset mid-frame, mid-line with de high
    run_frame(0, -1, 4);
    tick(1'b0, 1'b0, 1'b1, 24'h0A0B0C);
    tick(1'b0, 1'b0, 1'b1, 24'h0A0B0C);
    @(negedge clk);
    rst = 1'b1; hs = 1'b0; vs = 1'b0; de = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midreset");
    model_resync(1'b1);
    for (int i = 0; i < 3; i++) run_frame(0, -1, 10);
    run_frame(0, -1, 1);
    repeat (20) tick(1'b0, 1'b0, 1'b0, 24'h000000);

    check("pending_publishes", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
